// File: rtl/param_memory.sv
// Parameterised word memory with byte-lane write masks and a power-up clear
// sequence that fills every word with INITVAL before the first access is accepted.
module param_memory #(
    parameter int               DATAW   = 16,
    parameter int               ADDRW   = 5,
    parameter int               DEPTH   = 25,
    parameter logic [DATAW-1:0] INITVAL = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req,
    input  logic               wr,
    input  logic [ADDRW-1:0]   addr,
    input  logic [DATAW-1:0]   datain,
    input  logic [DATAW/8-1:0] wmask,
    output logic               ready,
    output logic [DATAW-1:0]   dataout,
    output logic               rvalid,
    output logic               err
);

    localparam int             NLANE   = DATAW / 8;
    localparam logic [ADDRW-1:0] LAST  = ADDRW'(DEPTH - 1);
    localparam logic [ADDRW:0] DEPTH_X = (ADDRW + 1)'(DEPTH);

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t           state, state_nxt;
    logic [ADDRW-1:0] clr_cnt, clr_cnt_nxt;
    logic [DATAW-1:0] mem [DEPTH];
    logic             acc;
    logic             in_range;

    assign acc      = req && ready;
    assign in_range = {1'b0, addr} < DEPTH_X;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        ready       = 1'b0;
        case (state)
            CLEAR: begin
                if (clr_cnt == LAST) begin
                    state_nxt = IDLE;
                end else begin
                    clr_cnt_nxt = clr_cnt + ADDRW'(1);
                end
            end
            IDLE: ready = 1'b1;
        endcase
    end

    // Storage has no reset; while rst is held the clear simply rewrites word 0.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_cnt] <= INITVAL;
        end else if (acc && wr && in_range) begin
            for (int i = 0; i < NLANE; i++) begin
                if (wmask[i]) begin
                    mem[addr][8*i +: 8] <= datain[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dataout <= '0;
            rvalid  <= 1'b0;
            err     <= 1'b0;
        end else begin
            rvalid <= acc && !wr;
            err    <= acc && !in_range;
            if (acc && !wr) begin
                dataout <= in_range ? mem[addr] : '0;
            end
        end
    end

endmodule

// File: tb/tb_param_memory.sv
// Directed bench for param_memory: a reference memory model feeds a queue of
// expected responses that is drained one cycle after each accepted request.
module tb_param_memory;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        wr;
    logic [4:0]  addr;
    logic [15:0] datain;
    logic [1:0]  wmask;
    logic        ready;
    logic [15:0] dataout;
    logic        rvalid;
    logic        err;

    typedef struct packed {
        logic        rv;
        logic        er;
        logic [15:0] d;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] mem_m [25];
    logic [15:0] last_dout;
    int          checks = 0;
    int          errors = 0;

    param_memory #(
        .DATAW  (16),
        .ADDRW  (5),
        .DEPTH  (25),
        .INITVAL(16'h0000)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .wr     (wr),
        .addr   (addr),
        .datain (datain),
        .wmask  (wmask),
        .ready  (ready),
        .dataout(dataout),
        .rvalid (rvalid),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 25; i++) mem_m[i] = 16'h0000;
    endtask

    // Drive one request, predict its response, and check it one cycle later.
    task automatic access(input logic w, input logic [4:0] a, input logic [15:0] d,
                          input logic [1:0] m);
        exp_t e;
        exp_t got;
        req = 1'b1; wr = w; addr = a; datain = d; wmask = m;
        chk("ready_before_access", ready, 1'b1);
        e.er = (a >= 5'd25);
        e.rv = !w;
        if (!w) begin
            e.d = e.er ? 16'h0000 : mem_m[a];
            last_dout = e.d;
        end else begin
            e.d = last_dout;
            if (!e.er) begin
                if (m[0]) mem_m[a][7:0]  = d[7:0];
                if (m[1]) mem_m[a][15:8] = d[15:8];
            end
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        req = 1'b0;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 1'b1, 1'b0);
        end else begin
            got = sb.pop_front();
            chk("rvalid", rvalid, got.rv);
            chk("err", err, got.er);
            chk("dataout", dataout, got.d);
        end
    endtask

    task automatic idle(input int n);
        req = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            chk("idle_rvalid", rvalid, 1'b0);
            chk("idle_err", err, 1'b0);
            chk("idle_dataout", dataout, last_dout);
        end
    endtask

    initial begin
        int n;
        rst = 1'b1; req = 1'b0; wr = 1'b0; addr = '0; datain = '0; wmask = '0;
        last_dout = 16'h0000;
        #1;
        chk("reset_ready", ready, 1'b0);
        chk("reset_rvalid", rvalid, 1'b0);
        chk("reset_err", err, 1'b0);
        chk("reset_dataout", dataout, 16'h0000);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_held_ready", ready, 1'b0);

        // Clear length after reset release
        rst = 1'b0;
        n = 0;
        while (ready !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("clear_edges", n, 25);
        model_clear();

        access(1'b0, 5'd0, 16'h0, 2'b00);
        access(1'b0, 5'd12, 16'h0, 2'b00);
        access(1'b0, 5'd24, 16'h0, 2'b00);
        idle(1);

        // Byte-lane merge
        access(1'b1, 5'd7, 16'hBEEF, 2'b11);
        access(1'b1, 5'd7, 16'h1234, 2'b01);
        access(1'b0, 5'd7, 16'h0, 2'b00);
        chk("merge_value", dataout, 16'hBE34);
        idle(1);

        // Write then read on consecutive edges
        access(1'b1, 5'd3, 16'hA5A5, 2'b11);
        access(1'b0, 5'd3, 16'h0, 2'b00);
        chk("rd_after_wr", dataout, 16'hA5A5);
        access(1'b1, 5'd9, 16'h00C3, 2'b01);
        access(1'b1, 5'd9, 16'h5A00, 2'b10);
        access(1'b0, 5'd9, 16'h0, 2'b00);

        // Zero mask writes nothing
        access(1'b1, 5'd5, 16'hFFFF, 2'b00);
        access(1'b0, 5'd5, 16'h0, 2'b00);
        idle(1);

        // Out-of-range accesses
        access(1'b0, 5'd25, 16'h0, 2'b00);
        access(1'b1, 5'd31, 16'hFFFF, 2'b11);
        idle(1);
        for (int i = 0; i < 25; i++) access(1'b0, 5'(i), 16'h0, 2'b00);
        idle(2);

        // Reset mid-clear, then hold req high through the whole clear
        rst = 1'b1;
        #1;
        chk("rst2_ready", ready, 1'b0);
        chk("rst2_dataout", dataout, 16'h0000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midclear_ready", ready, 1'b0);
        chk("midclear_rvalid", rvalid, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        last_dout = 16'h0000;
        req = 1'b1; wr = 1'b0; addr = 5'd7;
        n = 0;
        while (ready !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            chk("clear_window_rvalid", rvalid, 1'b0);
            chk("clear_window_err", err, 1'b0);
        end
        chk("reclear_edges", n, 25);
        model_clear();
        access(1'b0, 5'd7, 16'h0, 2'b00);
        access(1'b0, 5'd3, 16'h0, 2'b00);
        access(1'b0, 5'd9, 16'h0, 2'b00);
        idle(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/param_memory.md
PARAM_MEMORY -- requirements
Module: param_memory

Interface
REQ-001 SHALL have parameter DATAW, default 16, data word width in bits; a multiple of 8.
REQ-002 SHALL have parameter ADDRW, default 5, address width in bits.
REQ-003 SHALL have parameter DEPTH, default 25, number of words; 1 <= DEPTH <= 2^ADDRW.
REQ-004 SHALL have parameter INITVAL, default 0, DATAW-bit value written to every word by the clear sequence.
REQ-005 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port req, input, 1, access request.
REQ-008 SHALL have port wr, input, 1, 1 = write, 0 = read; sampled with req.
REQ-009 SHALL have port addr, input, ADDRW, word address.
REQ-010 SHALL have port datain, input, DATAW, write data.
REQ-011 SHALL have port wmask, input, DATAW/8, byte-lane write enable; bit i covers datain[8i+7:8i].
REQ-012 SHALL have port ready, output, 1, block accepts a request this cycle.
REQ-013 SHALL have port dataout, output, DATAW, registered read data.
REQ-014 SHALL have port rvalid, output, 1, one-cycle pulse marking a completed read.
REQ-015 SHALL have port err, output, 1, one-cycle pulse marking an out-of-range access.

Function
REQ-016 SHALL implement a two-state FSM: CLEAR and IDLE.
REQ-017 CLEAR: SHALL write INITVAL to word clr_cnt each cycle, clr_cnt counting 0..DEPTH-1; ready = 0.
REQ-018 CLEAR -> IDLE SHALL occur on the edge that writes word DEPTH-1; no other transition out of CLEAR exists.
REQ-019 IDLE: ready SHALL be 1 combinationally; FSM stays in IDLE until reset.
REQ-020 A request SHALL be accepted only on an edge where req && ready; req while ready = 0 SHALL be ignored, not queued.
REQ-021 Accepted write, addr < DEPTH: byte lanes with wmask bit set SHALL update at that edge; others unchanged; dataout, rvalid unchanged.
REQ-022 Accepted write with wmask = 0 SHALL leave memory unchanged and raise no error.
REQ-023 Accepted read, addr < DEPTH: dataout SHALL take mem[addr] at that edge; rvalid = 1 for the following cycle (1-cycle latency).
REQ-024 Read of an address written on the previous edge SHALL return the new data.
REQ-025 Accepted access with addr >= DEPTH: memory SHALL be unchanged; err = 1 for the following cycle; a read also sets dataout = 0 and rvalid = 1.
REQ-026 rvalid and err SHALL be 0 in every cycle not immediately following an accepted request that sets them.
REQ-027 dataout SHALL hold its last value until the next accepted read.
REQ-028 Back-to-back accepted requests on consecutive edges SHALL be supported at full throughput.

Reset
REQ-029 rst = 1 SHALL immediately force FSM = CLEAR, clr_cnt = 0, dataout = 0, rvalid = 0, err = 0, ready = 0.
REQ-030 Reset asserted mid-clear or mid-access SHALL abort the operation; any unfinished access is discarded and the full clear restarts after rst falls.
REQ-031 Memory contents SHALL NOT be reset asynchronously; they are defined only by the clear sequence.

Verification (DATAW=16, ADDRW=5, DEPTH=25, INITVAL=0)
REQ-032 Deassert rst -> ready = 0 for exactly 25 edges, then 1; reads of addr 0, 12, 24 return 0x0000 with rvalid pulses.
REQ-033 Write 0xBEEF to addr 7 with wmask = 2'b11, then write 0x1234 with wmask = 2'b01, then read addr 7 -> dataout = 0xBE34 one cycle after the read is accepted, rvalid = 1 for one cycle.
REQ-034 Write addr 3 = 0xA5A5 and read addr 3 on consecutive edges -> 0xA5A5 returned; rvalid = 0 in the cycle after the write.
REQ-035 Read addr 25, then write addr 31 -> err pulses once after each access; the read returns dataout = 0 with rvalid = 1; reading addr 0..24 afterwards shows no word changed.
REQ-036 Assert rst at clear cycle 10, release it, then hold req = 1 throughout -> no access is accepted until 25 edges after release; rvalid and err stay 0 during that window.
